// File: rtl/instruction_fetch_unit.sv
// IF stage: owns PC, prefetches into a small queue, resolves direct jumps.
// Ports: clock/reset_n; fetch_enable, branch_taken/branch_address (redirect);
// imem_en/imem_addr/imem_rdata (1-cycle memory); if_valid/if_ready/if_instr/
// if_pc (decode handshake).
module instruction_fetch_unit #(
  parameter int unsigned PC_WIDTH    = 10,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned RESET_PC    = 0,
  parameter logic [5:0]  JUMP_OPCODE = 6'b000010
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   fetch_enable,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_address,
  output logic                   imem_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [PC_WIDTH-1:0]    r_pc;
  logic                   r_inflight;
  logic [PC_WIDTH-1:0]    r_tag;
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [CW-1:0]          r_count;
  logic [INSTR_WIDTH-1:0] r_iq [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    r_pq [FIFO_DEPTH];

  logic          w_jump_hit;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic [CW-1:0] w_occ;

  assign w_jump_hit = r_inflight & ~branch_taken &
    (imem_rdata[INSTR_WIDTH-1 -: 6] == JUMP_OPCODE);
  assign w_push = r_inflight & ~branch_taken;
  assign w_pop  = if_valid & if_ready & ~branch_taken;

  // Credit check counts the in-flight word so a push never hits a full queue.
  assign w_occ   = r_count + {{AW{1'b0}}, r_inflight};
  assign w_issue = fetch_enable & ~branch_taken & ~w_jump_hit &
    (w_occ < CW'(FIFO_DEPTH));

  assign imem_en   = w_issue;
  assign imem_addr = r_pc;

  assign if_valid = (r_count != '0);
  assign if_instr = if_valid ? r_iq[r_rptr] : '0;
  assign if_pc    = if_valid ? r_pq[r_rptr] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= PC_WIDTH'(RESET_PC);
      r_inflight <= 1'b0;
      r_tag      <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_tag <= r_pc;
      unique case (1'b1)
        branch_taken: r_pc <= branch_address;
        w_jump_hit:   r_pc <= imem_rdata[PC_WIDTH-1:0];
        w_issue:      r_pc <= r_pc + 1'b1;
        default:      r_pc <= r_pc;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (branch_taken) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push & ~w_pop)
        r_count <= r_count + 1'b1;
      else if (~w_push & w_pop)
        r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible through if_valid.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_iq[r_wptr] <= imem_rdata;
      r_pq[r_wptr] <= r_tag;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: straight-line, back-pressure,
// jump, branch flush, branch-vs-jump and PC wrap / async reset.
module tb_instruction_fetch_unit;

  localparam int PW = 10;
  localparam int IW = 32;
  localparam logic [31:0] JWORD = {6'b000010, 26'd20};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n, fe, br, rdy;
  logic [PW-1:0] ba;
  logic          en;
  logic [PW-1:0] addr;
  logic [IW-1:0] rdata = '0;
  logic          vld;
  logic [IW-1:0] instr;
  logic [PW-1:0] pc;

  logic          reset_n2, fe2, rdy2;
  logic          en2;
  logic [PW-1:0] addr2;
  logic [IW-1:0] rdata2 = '0;
  logic          vld2;
  logic [IW-1:0] instr2;
  logic [PW-1:0] pc2;

  logic [IW-1:0] mem [0:1023];

  always @(posedge clock) if (en) rdata <= mem[addr];
  always @(posedge clock) if (en2) rdata2 <= mem[addr2];

  instruction_fetch_unit u_dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_enable(fe), .branch_taken(br),
    .branch_address(ba),
    .imem_en(en), .imem_addr(addr),
    .imem_rdata(rdata),
    .if_valid(vld), .if_ready(rdy),
    .if_instr(instr), .if_pc(pc)
  );

  instruction_fetch_unit #(.RESET_PC(1022)) u_wrap (
    .clock(clock), .reset_n(reset_n2),
    .fetch_enable(fe2), .branch_taken(1'b0),
    .branch_address(10'd0),
    .imem_en(en2), .imem_addr(addr2),
    .imem_rdata(rdata2),
    .if_valid(vld2), .if_ready(rdy2),
    .if_instr(instr2), .if_pc(pc2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          fe;
    logic          rdy;
    logic          br;
    logic [PW-1:0] ba;
    logic          en;
    logic [PW-1:0] addr;
    logic          vld;
    logic [PW-1:0] pc;
  } vec_t;

  vec_t jt[9];

  function automatic vec_t mk(logic f, logic r, logic b, int a,
                              logic e, int ad, logic v, int p);
    vec_t t;
    t.fe = f; t.rdy = r; t.br = b; t.ba = PW'(a);
    t.en = e; t.addr = PW'(ad); t.vld = v; t.pc = PW'(p);
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(logic f, logic r, logic b, logic [PW-1:0] a);
    @(negedge clock);
    fe = f; rdy = r; br = b; ba = a;
    #1;
  endtask

  task automatic step2(logic f, logic r);
    @(negedge clock);
    fe2 = f; rdy2 = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; fe = 1'b0; rdy = 1'b0; br = 1'b0; ba = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i;
    reset_n = 1'b0; fe = 1'b0; rdy = 1'b0; br = 1'b0; ba = '0;
    reset_n2 = 1'b0; fe2 = 1'b0; rdy2 = 1'b0;

    jt[0] = mk(1, 1, 0, 0, 1, 0,  0, 0);
    jt[1] = mk(1, 1, 0, 0, 1, 1,  0, 0);
    jt[2] = mk(1, 1, 0, 0, 1, 2,  1, 0);
    jt[3] = mk(1, 1, 0, 0, 1, 3,  1, 1);
    jt[4] = mk(1, 1, 0, 0, 0, 4,  1, 2);
    jt[5] = mk(1, 1, 0, 0, 1, 20, 1, 3);
    jt[6] = mk(1, 1, 0, 0, 1, 21, 0, 0);
    jt[7] = mk(1, 1, 0, 0, 1, 22, 1, 20);
    jt[8] = mk(1, 1, 0, 0, 1, 23, 1, 21);

    // Reset state
    do_reset();
    chk("rst_en",    32'(en),    32'd0);
    chk("rst_addr",  32'(addr),  32'd0);
    chk("rst_valid", 32'(vld),   32'd0);
    chk("rst_instr", instr,      32'd0);
    chk("rst_pc",    32'(pc),    32'd0);

    // Straight-line fetch
    for (int c = 0; c < 16; c++) begin
      step(1, 1, 0, '0);
      chk("sl_en",   32'(en),   32'd1);
      chk("sl_addr", 32'(addr), 32'(c));
      if (c >= 2) begin
        chk("sl_valid", 32'(vld), 32'd1);
        chk("sl_pc",    32'(pc),  32'(c - 2));
        chk("sl_instr", instr,    mem[pc]);
      end else begin
        chk("sl_valid0", 32'(vld), 32'd0);
      end
    end

    // Back-pressure then drain
    do_reset();
    for (int c = 0; c < 16; c++) begin
      step(1, (c >= 10), 0, '0);
      if (c < 4) begin
        chk("bp_en",   32'(en),   32'd1);
        chk("bp_addr", 32'(addr), 32'(c));
      end else if (c < 11) begin
        chk("bp_full_en", 32'(en), 32'd0);
      end
      if (c >= 2 && c < 10) begin
        chk("bp_hold_valid", 32'(vld), 32'd1);
        chk("bp_hold_pc",    32'(pc),  32'd0);
        chk("bp_hold_instr", instr,    32'd0);
      end
      if (c >= 10) begin
        chk("bp_drain_valid", 32'(vld), 32'd1);
        chk("bp_drain_pc",    32'(pc),  32'(c - 10));
        chk("bp_drain_instr", instr,    32'(c - 10));
      end
    end

    // Jump (table driven)
    mem[3] = JWORD;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(jt[i].fe, jt[i].rdy, jt[i].br, jt[i].ba);
      chk("jt_en",    32'(en),   32'(jt[i].en));
      chk("jt_addr",  32'(addr), 32'(jt[i].addr));
      chk("jt_valid", 32'(vld),  32'(jt[i].vld));
      if (jt[i].vld) begin
        chk("jt_pc",    32'(pc), 32'(jt[i].pc));
        chk("jt_instr", instr,   mem[jt[i].pc]);
      end
    end

    // Branch flush with 3 queued entries
    mem[3] = 32'd3;
    do_reset();
    for (int c = 0; c < 4; c++) step(1, 0, 0, '0);
    chk("bf_pre_en", 32'(en), 32'd1);
    step(1, 1, 1, PW'(100));
    chk("bf_br_en",    32'(en),  32'd0);
    chk("bf_br_valid", 32'(vld), 32'd1);
    chk("bf_br_pc",    32'(pc),  32'd0);
    step(1, 1, 0, '0);
    chk("bf_valid5", 32'(vld),  32'd0);
    chk("bf_en5",    32'(en),   32'd1);
    chk("bf_addr5",  32'(addr), 32'd100);
    step(1, 1, 0, '0);
    chk("bf_valid6", 32'(vld),  32'd0);
    chk("bf_addr6",  32'(addr), 32'd101);
    step(1, 1, 0, '0);
    chk("bf_valid7", 32'(vld), 32'd1);
    chk("bf_pc7",    32'(pc),  32'd100);
    chk("bf_instr7", instr,    32'd100);
    step(1, 1, 0, '0);
    chk("bf_pc8", 32'(pc), 32'd101);

    // Branch and jump in the same cycle
    mem[3] = JWORD;
    do_reset();
    for (int c = 0; c < 4; c++) step(1, 1, 0, '0);
    step(1, 1, 1, PW'(50));
    chk("bj_en4", 32'(en), 32'd0);
    step(1, 1, 0, '0);
    chk("bj_valid5", 32'(vld),  32'd0);
    chk("bj_addr5",  32'(addr), 32'd50);
    step(1, 1, 0, '0);
    chk("bj_valid6", 32'(vld), 32'd0);
    step(1, 1, 0, '0);
    chk("bj_valid7", 32'(vld), 32'd1);
    chk("bj_pc7",    32'(pc),  32'd50);
    chk("bj_instr7", instr,    32'd50);
    mem[3] = 32'd3;

    // Wrap and asynchronous reset
    @(negedge clock);
    reset_n2 = 1'b1;
    #1;
    chk("wr_rst_addr", 32'(addr2), 32'd1022);
    for (int c = 0; c < 6; c++) begin
      step2(1, 1);
      if (c < 3) chk("wr_addr", 32'(addr2), 32'((1022 + c) % 1024));
      if (c >= 2) begin
        chk("wr_pc",    32'(pc2), 32'((1020 + c) % 1024));
        chk("wr_instr", instr2,   32'((1020 + c) % 1024));
      end
    end
    chk("wr_pre_valid", 32'(vld2), 32'd1);
    reset_n2 = 1'b0;
    #1;
    chk("wr_async_valid", 32'(vld2),  32'd0);
    chk("wr_async_pc",    32'(pc2),   32'd0);
    chk("wr_async_instr", instr2,     32'd0);
    fe2 = 1'b0;
    repeat (2) @(negedge clock);
    reset_n2 = 1'b1;
    #1;
    chk("wr_rel_addr",  32'(addr2), 32'd1022);
    chk("wr_rel_valid", 32'(vld2),  32'd0);
    step2(1, 1);
    chk("wr_re_en",   32'(en2),   32'd1);
    chk("wr_re_addr", 32'(addr2), 32'd1022);
    step2(1, 1);
    chk("wr_re_valid1", 32'(vld2), 32'd0);
    step2(1, 1);
    chk("wr_re_valid2", 32'(vld2), 32'd1);
    chk("wr_re_pc",     32'(pc2),  32'd1022);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
